serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial adder/subtractor that reuses the team's one-bit full-adder equations, one bit per clock, LSB first. It sits downstream of the operand registers and upstream of the 4-bit ALU result mux. It is a low-area alternative to the ripple-carry path. A start/ready/done handshake sequences each operation, and the block reports the result, carry-out, overflow and zero flags.

## Interface
- WIDTH, 4, operand and result width in bits (WIDTH >= 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only while ready=1
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A, unsigned or two's complement; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  block can accept start (high in IDLE and DONE)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result becomes valid
- result  output  WIDTH  sum/difference, held until the next accepted start
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  output  1  signed overflow (carry into MSB xor carry out of MSB)
- zero  output  1  result == 0

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst=1 at a clock edge, any state, including mid-RUN):
  - state=IDLE; ready=1; busy=0; done=0.
  - result=0; cout=0; ovf=0; zero=0.
  - Internal shift registers, carry flop and bit counter are cleared.
- IDLE:
  - ready=1.
  - start=1 → latch A=a, B=(sub ? ~b : b), carry=sub, count=0; go to RUN.
- RUN:
  - Each cycle, bit i = count. Use A[0], B[0], carry in the full-adder equations: s = A[0]^B[0]^carry, c = majority(A[0],B[0],carry).
  - Shift A and B right by 1. Shift s into the result shift register at the MSB end, shifting right. carry ← c.
  - When count = WIDTH-2, record cin_msb = c. This is the carry into the MSB.
  - When count = WIDTH-1, go to DONE and load the outputs: result ← shifted value, cout ← c, ovf ← cin_msb ^ c, zero ← (final result == 0). Otherwise count ← count+1.
  - start is ignored in RUN; ready=0.
- DONE:
  - done=1 for exactly this cycle; ready=1.
  - start=1 → accept a new operation exactly as in IDLE and go to RUN. result and the flags keep their old values until the new operation completes.
  - Otherwise go to IDLE.
- result, cout, ovf and zero change only on the edge entering DONE, or on reset.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Start accepted at edge E0 → busy=1 after E0.
- RUN occupies WIDTH cycles, edges E1..E_WIDTH.
- State=DONE and the outputs are valid after edge E_WIDTH. done is high during the cycle between E_WIDTH and E_WIDTH+1.
- Latency from the start-accepting edge to done: WIDTH edges.
- Back-to-back throughput: one operation per WIDTH+1 cycles. Start is asserted in the DONE cycle.
- ready is registered, decoded from state: ready = (state != RUN). busy = (state == RUN).
- The a, b and sub inputs may change freely after the accepting edge.

## Test plan
- WIDTH=4, add 7+1 → after 4 edges done=1, result=4'b1000, cout=0, ovf=1, zero=0.
- Add 15+1 → result=4'b0000, cout=1, ovf=0, zero=1.
- Subtract 5-3 → result=4'b0010, cout=1, ovf=0. Subtract 3-5 → result=4'b1110, cout=0, ovf=0.
- Subtract 8-1 (signed -8-1) → result=4'b0111, ovf=1, cout=1.
- Busy and reset behaviour:
  - Pulse start with new operands mid-RUN → ignored; the original result completes.
  - Assert rst at the 2nd RUN cycle → next cycle ready=1, busy=0, done=0, result=0, all flags 0.
- Exhaustive checks against a reference model:
  - All 256 (a,b) pairs × sub∈{0,1}, issued back-to-back with start asserted in each DONE cycle.
  - Compare with {cout,result} = a + (sub ? ~b : b) + sub, ovf and zero.
  - done must pulse exactly once per operation, spaced 5 cycles apart.

Source files
------------

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: handshake and result bundle for the bit-serial adder/subtractor.
//   master: drives start/sub/a/b and observes status and results (requester side)
//   slave : the serial_addsub datapath
//   start/sub/a/b  : operation request, sampled while ready=1
//   ready/busy/done: sequencing status; done pulses one cycle per result
//   result/cout/ovf/zero : sum/difference and flags, held until the next completion
interface serial_addsub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, one bit per clock, LSB first.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_addsub_if.slave (start/sub/a/b in; ready/busy/done/result/cout/ovf/zero out)
// An accepted start is followed by WIDTH RUN cycles; the outputs load on the
// edge entering DONE and are held until the next completion or reset.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic             cin_msb;
  logic [CW-1:0]    count;

  logic             s;
  logic             c;
  logic [WIDTH-1:0] r_next;

  // One full-adder slice on the current LSBs; sum enters the result at the MSB
  // so that after WIDTH shifts bit 0 has landed in position 0.
  always_comb begin
    s      = a_sh[0] ^ b_sh[0] ^ carry;
    c      = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    r_next = {s, r_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus.ready  <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.zero   <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      carry      <= 1'b0;
      cin_msb    <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          carry <= c;
          if (count == CW'(WIDTH-2)) cin_msb <= c;
          if (count == CW'(WIDTH-1)) begin
            state      <= DONE;
            bus.ready  <= 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.result <= r_next;
            bus.cout   <= c;
            // cin_msb was captured a cycle earlier, so it is the MSB carry-in here
            bus.ovf    <= cin_msb ^ c;
            bus.zero   <= (r_next == '0);
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin  // IDLE and DONE accept a new operation identically
          bus.done <= 1'b0;
          if (bus.start) begin
            state     <= RUN;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            a_sh      <= bus.a;
            // subtract as a + ~b + 1: the +1 rides in as the initial carry
            b_sh      <= bus.sub ? ~bus.b : bus.b;
            carry     <= bus.sub;
            count     <= '0;
          end else begin
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub (WIDTH=4).
// Stimulus pushes the expected response when a start is accepted; a monitor
// pops and compares on every done pulse.
module tb_serial_addsub;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int SMAX  = (1 << (WIDTH-1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH-1));

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    total = 0;
  int    bad = 0;
  resp_t expq[$];
  bit    b2b = 1'b0;
  int    cyc = 0;
  int    last_done = -1;

  serial_addsub_if #(.WIDTH(WIDTH)) bus();
  serial_addsub #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed overflow by range check.
  function automatic resp_t model(input int a, input int b, input bit sub);
    int    full, sa, sb, sr;
    resp_t r;
    full     = a + (sub ? (~b & MASK) : b) + int'(sub);
    sa       = (a > SMAX) ? a - (1 << WIDTH) : a;
    sb       = (b > SMAX) ? b - (1 << WIDTH) : b;
    sr       = sub ? sa - sb : sa + sb;
    r.result = WIDTH'(full & MASK);
    r.cout   = ((full >> WIDTH) & 1) != 0;
    r.ovf    = (sr > SMAX) || (sr < SMIN);
    r.zero   = (full & MASK) == 0;
    return r;
  endfunction

  function automatic resp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic o, input logic z);
    resp_t x;
    x.result = r; x.cout = c; x.ovf = o; x.zero = z;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on done, plus spacing check in back-to-back mode.
  always @(negedge clk) begin
    resp_t act, e;
    cyc++;
    if (!rst && bus.done) begin
      if (b2b) begin
        if (last_done >= 0) chk("done_spacing", cyc - last_done, WIDTH + 1);
        last_done = cyc;
      end
      act = mk(bus.result, bus.cout, bus.ovf, bus.zero);
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got %h with empty scoreboard", act);
      end else begin
        e = expq.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL result: got {res,cout,ovf,zero}=%h expected %h", act, e);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit sub, input resp_t e);
    int n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      bad++; total++;
      $display("FAIL ready_timeout: ready=%b expected 1", bus.ready);
      return;
    end
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
    @(posedge clk);
    expq.push_back(e);
    #1;
    bus.start = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.sub = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      bad++; total++;
      $display("FAIL drain_timeout: pending=%0d expected 0", expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations
    issue(4'd7, 4'd1, 1'b0, mk(4'b1000, 1'b0, 1'b1, 1'b0));
    chk("run_busy",  int'(bus.busy), 1);
    chk("run_ready", int'(bus.ready), 0);
    drain();
    issue(4'd15, 4'd1, 1'b0, mk(4'b0000, 1'b1, 1'b0, 1'b1)); drain();
    issue(4'd5,  4'd3, 1'b1, mk(4'b0010, 1'b1, 1'b0, 1'b0)); drain();
    issue(4'd3,  4'd5, 1'b1, mk(4'b1110, 1'b0, 1'b0, 1'b0)); drain();
    issue(4'd8,  4'd1, 1'b1, mk(4'b0111, 1'b1, 1'b1, 1'b0)); drain();

    // start pulsed mid-RUN with different operands must be ignored
    issue(4'd6, 4'd2, 1'b0, mk(4'b1000, 1'b0, 1'b1, 1'b0));
    bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd15; bus.sub = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    // Reset in the 2nd RUN cycle clears everything; the aborted op never completes
    issue(4'd9, 4'd4, 1'b0, model(9, 4, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", int'(bus.ready), 1);
    chk("midrst_busy",  int'(bus.busy), 0);
    chk("midrst_done",  int'(bus.done), 0);
    chk("midrst_result", int'(bus.result), 0);
    chk("midrst_flags", int'({bus.cout, bus.ovf, bus.zero}), 0);
    rst = 1'b0;
    void'(expq.pop_back());
    repeat (8) @(negedge clk);

    // Exhaustive back-to-back sweep
    b2b = 1'b1; last_done = -1;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x <= MASK; x++)
        for (int y = 0; y <= MASK; y++)
          issue(WIDTH'(x), WIDTH'(y), s[0], model(x, y, s[0]));
    drain();
    b2b = 1'b0;

    // Randomized operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int x, y; bit s;
      x = int'($urandom_range(MASK, 0));
      y = int'($urandom_range(MASK, 0));
      s = 1'($urandom);
      issue(WIDTH'(x), WIDTH'(y), s, model(x, y, s));
      repeat ($urandom_range(6, 0)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
